regfile_arb: RTL and testbench

REGFILE_ARB -- requirements
Module: regfile_arb

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/rr_pick2.sv | 29 ++
 rtl/regfile_arb.sv | 135 +++++++++++++
 tb/tb_regfile_arb.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter.
//   state_e         : arbiter FSM states (idle, step read, step write)
//   TRAP/ALU/STP    : requester indices into the grant vector
//   RegSp/RegPc     : register numbers that always step by a full word
package regfile_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStpRd = 2'd1,
    StStpWr = 2'd2
  } state_e;

  localparam int unsigned TRAP   = 0;
  localparam int unsigned ALU    = 1;
  localparam int unsigned STP    = 2;
  localparam int unsigned NumReq = 3;

  localparam int unsigned RegSp = 6;
  localparam int unsigned RegPc = 7;

endpackage

// File: rtl/rr_pick2.sv
// Fixed-priority plus two-way round-robin selector.
//   hi_req        : highest-priority request, always wins when present
//   req_a / req_b : round-robin pair
//   prefer_b      : 0 = a preferred on a tie, 1 = b preferred
//   gnt_hi/a/b    : one-hot (or all zero) selection, purely combinational
module rr_pick2 (
  input  logic hi_req,
  input  logic req_a,
  input  logic req_b,
  input  logic prefer_b,
  output logic gnt_hi,
  output logic gnt_a,
  output logic gnt_b
);

  always_comb begin
    gnt_hi = hi_req;
    gnt_a  = 1'b0;
    gnt_b  = 1'b0;
    if (!hi_req) begin
      if (req_a && (!prefer_b || !req_b)) begin
        gnt_a = 1'b1;
      end else if (req_b) begin
        gnt_b = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_arb.sv
// Write-port arbiter in front of an external register file.
//   clk, reset                     : clock, asynchronous active-high reset
//   trap_req/reg/data, trap_gnt    : trap vector load, fixed highest priority
//   alu_req/reg/data, alu_gnt      : ALU writeback, single-cycle write
//   stp_req/reg/dec/byte, stp_gnt  : autoinc/autodec, read-modify-write over two cycles
//   rd_sela, rd_selb, rd_b_ok      : datapath read selects; rd_b_ok flags B-bus ownership
//   rf_sela/selb/we/w, rf_b        : register file connection
//   busy                           : a step sequence is in progress
module regfile_arb
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SELW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trap_req,
  input  logic [SELW-1:0]  trap_reg,
  input  logic [WIDTH-1:0] trap_data,
  output logic             trap_gnt,
  input  logic             alu_req,
  input  logic [SELW-1:0]  alu_reg,
  input  logic [WIDTH-1:0] alu_data,
  output logic             alu_gnt,
  input  logic             stp_req,
  input  logic [SELW-1:0]  stp_reg,
  input  logic             stp_dec,
  input  logic             stp_byte,
  output logic             stp_gnt,
  input  logic [SELW-1:0]  rd_sela,
  input  logic [SELW-1:0]  rd_selb,
  output logic             rd_b_ok,
  output logic [SELW-1:0]  rf_sela,
  output logic [SELW-1:0]  rf_selb,
  output logic             rf_we,
  output logic [WIDTH-1:0] rf_w,
  input  logic [WIDTH-1:0] rf_b,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;  // 0: ALU preferred, 1: STP preferred
  logic [WIDTH-1:0] temp_q, temp_d;

  logic             pick_trap, pick_alu, pick_stp;
  logic [NumReq-1:0] gnt;
  logic             word_only;
  logic [WIDTH-1:0] delta;
  logic [WIDTH-1:0] step_sum;

  rr_pick2 u_pick (
    .hi_req   (trap_req),
    .req_a    (alu_req),
    .req_b    (stp_req),
    .prefer_b (ptr_q),
    .gnt_hi   (pick_trap),
    .gnt_a    (pick_alu),
    .gnt_b    (pick_stp)
  );

  // SP and PC must stay word aligned, so byte steps are widened for them.
  assign word_only = (stp_reg == SELW'(RegSp)) || (stp_reg == SELW'(RegPc));
  assign delta     = (stp_byte && !word_only) ? WIDTH'(1) : WIDTH'(2);
  assign step_sum  = stp_dec ? (temp_q - delta) : (temp_q + delta);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    temp_d  = temp_q;
    rf_selb = rd_selb;
    rf_we   = 1'b0;
    rf_w    = '0;
    gnt     = '0;

    unique case (state_q)
      StIdle: begin
        if (pick_trap) begin
          rf_selb   = trap_reg;
          rf_w      = trap_data;
          rf_we     = 1'b1;
          gnt[TRAP] = 1'b1;
        end else if (pick_alu) begin
          rf_selb  = alu_reg;
          rf_w     = alu_data;
          rf_we    = 1'b1;
          gnt[ALU] = 1'b1;
          ptr_d    = 1'b1;
        end else if (pick_stp) begin
          rf_selb = stp_reg;
          state_d = StStpRd;
          ptr_d   = 1'b0;
        end
      end
      StStpRd: begin
        rf_selb = stp_reg;
        temp_d  = rf_b;
        state_d = StStpWr;
      end
      StStpWr: begin
        rf_selb  = stp_reg;
        rf_w     = step_sum;
        rf_we    = 1'b1;
        gnt[STP] = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Grants are combinational from the requests; hold them off during reset.
    if (reset) begin
      rf_we = 1'b0;
      gnt   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      temp_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      temp_q  <= temp_d;
    end
  end

  assign trap_gnt = gnt[TRAP];
  assign alu_gnt  = gnt[ALU];
  assign stp_gnt  = gnt[STP];
  assign rf_sela  = rd_sela;
  assign rd_b_ok  = (rf_selb == rd_selb);
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_regfile_arb.sv
module tb_regfile_arb;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SELW  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             trap_req;
  logic [SELW-1:0]  trap_reg;
  logic [WIDTH-1:0] trap_data;
  logic             trap_gnt;
  logic             alu_req;
  logic [SELW-1:0]  alu_reg;
  logic [WIDTH-1:0] alu_data;
  logic             alu_gnt;
  logic             stp_req;
  logic [SELW-1:0]  stp_reg;
  logic             stp_dec;
  logic             stp_byte;
  logic             stp_gnt;
  logic [SELW-1:0]  rd_sela;
  logic [SELW-1:0]  rd_selb;
  logic             rd_b_ok;
  logic [SELW-1:0]  rf_sela;
  logic [SELW-1:0]  rf_selb;
  logic             rf_we;
  logic [WIDTH-1:0] rf_w;
  logic [WIDTH-1:0] rf_b;
  logic             busy;

  // Register file lives in the bench, with a side port for preloading.
  logic [WIDTH-1:0] regs [8];
  logic             ld_en;
  logic [SELW-1:0]  ld_sel;
  logic [WIDTH-1:0] ld_val;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) regs[ld_sel] <= ld_val;
    else if (rf_we) regs[rf_selb] <= rf_w;
  end
  assign rf_b = regs[rf_selb];

  regfile_arb #(.WIDTH(WIDTH), .SELW(SELW)) dut (
    .clk       (clk),
    .reset     (reset),
    .trap_req  (trap_req),
    .trap_reg  (trap_reg),
    .trap_data (trap_data),
    .trap_gnt  (trap_gnt),
    .alu_req   (alu_req),
    .alu_reg   (alu_reg),
    .alu_data  (alu_data),
    .alu_gnt   (alu_gnt),
    .stp_req   (stp_req),
    .stp_reg   (stp_reg),
    .stp_dec   (stp_dec),
    .stp_byte  (stp_byte),
    .stp_gnt   (stp_gnt),
    .rd_sela   (rd_sela),
    .rd_selb   (rd_selb),
    .rd_b_ok   (rd_b_ok),
    .rf_sela   (rf_sela),
    .rf_selb   (rf_selb),
    .rf_we     (rf_we),
    .rf_w      (rf_w),
    .rf_b      (rf_b),
    .busy      (busy)
  );

  // Expected step result: +/-1 for byte steps of R0..R5, +/-2 otherwise, modulo 2^16.
  function automatic logic [WIDTH-1:0] ref_step(input logic [WIDTH-1:0] v,
                                                 input logic [SELW-1:0] r,
                                                 input logic dec, input logic byt);
    int d;
    int s;
    d = (byt && (int'(r) < 6)) ? 1 : 2;
    s = int'(v) + (dec ? -d : d);
    if (s < 0) s = s + 65536;
    if (s >= 65536) s = s - 65536;
    return s[WIDTH-1:0];
  endfunction

  task automatic preload(input logic [SELW-1:0] sel, input logic [WIDTH-1:0] val);
    @(negedge clk);
    ld_en = 1'b1; ld_sel = sel; ld_val = val;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    trap_req = 1'b1; trap_reg = 3'd5; trap_data = 16'hBEEF;
    alu_req = 1'b1; alu_reg = 3'd1; alu_data = 16'h1111;
    stp_req = 1'b1; stp_reg = 3'd2; stp_dec = 1'b0; stp_byte = 1'b0;
    rd_sela = 3'd2; rd_selb = 3'd4;
    #1 reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({trap_gnt, alu_gnt, stp_gnt} !== 3'b000) begin
      failures++; $display("FAIL reset_gnt got=%b want=000", {trap_gnt, alu_gnt, stp_gnt});
    end
    checks++;
    if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b want=0", rf_we); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (rf_sela !== 3'd2) begin failures++; $display("FAIL reset_sela got=%0d want=2", rf_sela); end
    trap_req = 1'b0; alu_req = 1'b0; stp_req = 1'b0;
    for (int i = 0; i < 8; i++) preload(3'(i), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (rf_selb !== 3'd4) begin failures++; $display("FAIL idle_selb got=%0d want=4", rf_selb); end
    checks++;
    if (rd_b_ok !== 1'b1) begin failures++; $display("FAIL idle_b_ok got=%b want=1", rd_b_ok); end
    checks++;
    if (rf_we !== 1'b0) begin failures++; $display("FAIL idle_we got=%b want=0", rf_we); end
  endtask

  task automatic test_alu_write;
    @(negedge clk);
    alu_req = 1'b1; alu_reg = 3'd3; alu_data = 16'h1234;
    #1;
    checks++;
    if ({alu_gnt, rf_we} !== 2'b11) begin
      failures++; $display("FAIL alu_gnt_we got=%b want=11", {alu_gnt, rf_we});
    end
    checks++;
    if (rf_selb !== 3'd3 || rf_w !== 16'h1234) begin
      failures++; $display("FAIL alu_bus got=%0d/%h want=3/1234", rf_selb, rf_w);
    end
    checks++;
    if (rd_b_ok !== 1'b0) begin failures++; $display("FAIL alu_b_ok got=%b want=0", rd_b_ok); end
    @(posedge clk); #1;
    alu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (regs[3] !== 16'h1234) begin
      failures++; $display("FAIL alu_r3 got=%h want=1234", regs[3]);
    end
  endtask

  task automatic test_step_dec;
    preload(3'd2, 16'h0000);
    @(negedge clk);
    stp_req = 1'b1; stp_reg = 3'd2; stp_dec = 1'b1; stp_byte = 1'b0;
    #1;
    checks++;
    if ({stp_gnt, rf_we, rf_selb} !== {2'b00, 3'd2}) begin
      failures++; $display("FAIL step_win got=%b/%b/%0d want=0/0/2", stp_gnt, rf_we, rf_selb);
    end
    @(negedge clk); #1;
    checks++;
    if ({busy, rf_we, stp_gnt} !== 3'b100) begin
      failures++; $display("FAIL step_rd got=%b want=100", {busy, rf_we, stp_gnt});
    end
    @(negedge clk); #1;
    checks++;
    if ({stp_gnt, rf_we} !== 2'b11 || rf_w !== 16'hFFFE) begin
      failures++; $display("FAIL step_wr got=%b/%h want=11/fffe", {stp_gnt, rf_we}, rf_w);
    end
    @(posedge clk); #1;
    stp_req = 1'b0;
    @(negedge clk);
    checks++;
    if (regs[2] !== 16'hFFFE || busy !== 1'b0) begin
      failures++; $display("FAIL step_r2 got=%h/%b want=fffe/0", regs[2], busy);
    end
  endtask

  task automatic test_step_table;
    logic [SELW-1:0]  t_reg  [5] = '{3'd6, 3'd0, 3'd5, 3'd7, 3'd4};
    logic [WIDTH-1:0] t_init [5] = '{16'h1000, 16'hFFFF, 16'h0010, 16'h0001, 16'h7FFF};
    logic             t_dec  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic             t_byte [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      logic [WIDTH-1:0] want;
      int lat;
      bit got;
      want = ref_step(t_init[i], t_reg[i], t_dec[i], t_byte[i]);
      preload(t_reg[i], t_init[i]);
      @(negedge clk);
      stp_req = 1'b1; stp_reg = t_reg[i]; stp_dec = t_dec[i]; stp_byte = t_byte[i];
      got = 1'b0; lat = 0;
      for (int k = 0; k < 8; k++) begin
        #1;
        if (stp_gnt === 1'b1) begin got = 1'b1; lat = k; break; end
        @(negedge clk);
      end
      checks++;
      if (!got || lat != 2) begin
        failures++; $display("FAIL step_lat[%0d] got=%0d seen=%0b want=2", i, lat, got);
      end
      @(posedge clk); #1;
      stp_req = 1'b0;
      @(negedge clk);
      checks++;
      if (regs[t_reg[i]] !== want) begin
        failures++; $display("FAIL step_val[%0d] got=%h want=%h", i, regs[t_reg[i]], want);
      end
    end
  endtask

  task automatic test_rr_trap;
    int exp_order [5] = '{1, 2, 0, 1, 2};
    int order [5];
    int when  [5];
    int ng = 0;
    int c = 0;
    int alu_n = 0;
    int stp_n = 0;
    bit trap_sent = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    alu_req = 1'b1; alu_reg = 3'd1; alu_data = 16'h0101;
    stp_req = 1'b1; stp_reg = 3'd4; stp_dec = 1'b0; stp_byte = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    while (ng < 5 && c < 40) begin
      logic [2:0] g;
      #1;
      g = {trap_gnt, alu_gnt, stp_gnt};
      checks++;
      if ($countones(g) > 1) begin failures++; $display("FAIL rr_onehot got=%b want<=1", g); end
      if (g != 3'b000) begin
        order[ng] = g[2] ? 0 : (g[1] ? 1 : 2);
        when[ng]  = c;
        ng++;
      end
      @(posedge clk); #1;
      if (g[2]) trap_req = 1'b0;
      if (g[1]) begin
        alu_n++;
        if (alu_n < 2) alu_data = alu_data + 16'h0101; else alu_req = 1'b0;
      end
      if (g[0]) begin
        stp_n++;
        if (stp_n >= 2) stp_req = 1'b0;
      end
      if (busy && !trap_sent) begin
        trap_sent = 1'b1;
        trap_req = 1'b1; trap_reg = 3'd7; trap_data = 16'hABCD;
      end
      @(negedge clk);
      c++;
    end
    checks++;
    if (ng != 5) begin failures++; $display("FAIL rr_count got=%0d want=5", ng); end
    for (int i = 0; i < ng; i++) begin
      checks++;
      if (order[i] != exp_order[i]) begin
        failures++; $display("FAIL rr_order[%0d] got=%0d want=%0d", i, order[i], exp_order[i]);
      end
    end
    if (ng >= 3) begin
      checks++;
      if (when[2] != when[1] + 1) begin
        failures++; $display("FAIL trap_after_stp got=%0d want=%0d", when[2], when[1] + 1);
      end
    end
    trap_req = 1'b0; alu_req = 1'b0; stp_req = 1'b0;
  endtask

  task automatic test_reset_mid_step;
    preload(3'd1, 16'h0005);
    @(negedge clk);
    stp_req = 1'b1; stp_reg = 3'd1; stp_dec = 1'b0; stp_byte = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_pre got=%b want=1", busy); end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, rf_we, stp_gnt} !== 3'b000) begin
      failures++; $display("FAIL abort_now got=%b want=000", {busy, rf_we, stp_gnt});
    end
    @(negedge clk);
    stp_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (regs[1] !== 16'h0005 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_r1 got=%h/%b want=0005/0", regs[1], busy);
    end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] m_regs [8];
    int phase = 0;     // 0 idle, 1 step reading, 2 step writing
    bit alu_turn = 1'b1;
    int n = 10000;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 16'($urandom);
      preload(3'(i), m_regs[i]);
    end
    for (int cyc = 0; cyc < n; cyc++) begin
      bit e_trap, e_alu, e_stp, e_we;
      logic [SELW-1:0]  e_selb;
      logic [WIDTH-1:0] e_w;
      @(negedge clk);
      e_trap = 0; e_alu = 0; e_stp = 0; e_we = 0; e_selb = rd_selb; e_w = '0;
      if (phase == 0) begin
        if (trap_req) begin
          e_trap = 1; e_we = 1; e_selb = trap_reg; e_w = trap_data;
        end else if (alu_req && (alu_turn || !stp_req)) begin
          e_alu = 1; e_we = 1; e_selb = alu_reg; e_w = alu_data;
        end else if (stp_req) begin
          e_selb = stp_reg;
        end
      end else if (phase == 1) begin
        e_selb = stp_reg;
      end else begin
        e_stp = 1; e_we = 1; e_selb = stp_reg;
        e_w = ref_step(m_regs[stp_reg], stp_reg, stp_dec, stp_byte);
      end
      checks++;
      if ({trap_gnt, alu_gnt, stp_gnt} !== {e_trap, e_alu, e_stp}) begin
        failures++; $display("FAIL rnd_gnt cyc=%0d got=%b want=%b", cyc,
                             {trap_gnt, alu_gnt, stp_gnt}, {e_trap, e_alu, e_stp});
      end
      checks++;
      if ($countones({trap_gnt, alu_gnt, stp_gnt}) > 1) begin
        failures++; $display("FAIL rnd_onehot cyc=%0d got=%b want<=1", cyc,
                             {trap_gnt, alu_gnt, stp_gnt});
      end
      checks++;
      if (rf_we !== e_we || busy !== (phase != 0)) begin
        failures++; $display("FAIL rnd_we_busy cyc=%0d got=%b/%b want=%b/%b", cyc, rf_we, busy,
                             e_we, phase != 0);
      end
      checks++;
      if (rf_selb !== e_selb || rf_sela !== rd_sela) begin
        failures++; $display("FAIL rnd_sel cyc=%0d got=%0d/%0d want=%0d/%0d", cyc, rf_selb,
                             rf_sela, e_selb, rd_sela);
      end
      checks++;
      if (rd_b_ok !== (e_selb == rd_selb)) begin
        failures++; $display("FAIL rnd_b_ok cyc=%0d got=%b want=%b", cyc, rd_b_ok,
                             e_selb == rd_selb);
      end
      if (e_we) begin
        checks++;
        if (rf_w !== e_w) begin
          failures++; $display("FAIL rnd_w cyc=%0d got=%h want=%h", cyc, rf_w, e_w);
        end
      end
      if (failures > 40) break;
      // Advance the reference model to match the coming rising edge.
      if (phase == 0) begin
        if (e_trap) m_regs[trap_reg] = trap_data;
        else if (e_alu) begin m_regs[alu_reg] = alu_data; alu_turn = 1'b0; end
        else if (stp_req) begin phase = 1; alu_turn = 1'b1; end
      end else if (phase == 1) begin
        phase = 2;
      end else begin
        m_regs[stp_reg] = e_w;
        phase = 0;
      end
      @(posedge clk); #1;
      if (e_trap) trap_req = 1'b0;
      if (e_alu) alu_req = 1'b0;
      if (e_stp) stp_req = 1'b0;
      if (cyc < n - 20) begin
        if (!trap_req && $urandom_range(7) == 0) begin
          trap_req = 1'b1; trap_reg = 3'($urandom); trap_data = 16'($urandom);
        end
        if (!alu_req && $urandom_range(2) == 0) begin
          alu_req = 1'b1; alu_reg = 3'($urandom); alu_data = 16'($urandom);
        end
        if (!stp_req && $urandom_range(2) == 0) begin
          stp_req = 1'b1; stp_reg = 3'($urandom);
          stp_dec = 1'($urandom); stp_byte = 1'($urandom);
        end
      end
      rd_sela = 3'($urandom);
      rd_selb = 3'($urandom);
    end
    @(negedge clk);
    checks++;
    if ({trap_req, alu_req, stp_req} !== 3'b000) begin
      failures++; $display("FAIL rnd_drain got=%b want=000", {trap_req, alu_req, stp_req});
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (regs[i] !== m_regs[i]) begin
        failures++; $display("FAIL rnd_reg[%0d] got=%h want=%h", i, regs[i], m_regs[i]);
      end
    end
    trap_req = 1'b0; alu_req = 1'b0; stp_req = 1'b0;
  endtask

  initial begin
    ld_en = 1'b0; ld_sel = '0; ld_val = '0;
    test_reset;
    test_alu_write;
    test_step_dec;
    test_step_table;
    test_rr_trap;
    test_reset_mid_step;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
